wb_switch_param: RTL and testbench
==================================

# wb_switch_param

Parametrised single-master Wishbone classic interconnect for the peripheral bus, sitting between the BIU peripheral port and up to 16 slaves (GPIO, UART, keyboard, RTC, PIT, PIC pair, future devices). It decodes a slave index from the address, registers the request, and holds it on the selected slave until that slave acks. It returns read data with a registered ack. It adds behaviour the fixed seven-slave switch lacks: a base-address window check, an error response for unmapped slots, and a per-transaction timeout watchdog.

## Interface
- NUM_SLAVES, 7: populated slave ports, 1..16.
- SEL_LSB, 12: lowest address bit of the slave-index field.
- SEL_W, 4: width of the slave-index field; 2^SEL_W ≥ NUM_SLAVES.
- BASE_ADDR, 32'h1000_0000: the window matches when adr[31:SEL_LSB+SEL_W] equals BASE_ADDR over the same bits.
- TIMEOUT, 255: cycles in ACTIVE without ack before an error response; 0 disables the watchdog.
- TIMEOUT_W, 8: counter width; 2^TIMEOUT_W > TIMEOUT.
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- master_stb_i / master_we_i  in  1 / 1  master request and write enable.
- master_adr_i / master_dat_i  in  32 / 32  address and write data.
- master_sel_i  in  4  byte selects.
- master_dat_o  out  32  registered read data.
- master_ack_o  out  1  one-cycle completion pulse.
- master_err_o  out  1  one-cycle error pulse, coincident with master_ack_o.
- master_tmo_o  out  1  one-cycle pulse, coincident with master_err_o when the cause is timeout.
- slave_stb_o / slave_cyc_o / slave_we_o  out  NUM_SLAVES each  per-slave strobe, cycle and write enable.
- slave_adr_o  out  NUM_SLAVES*32  flattened per-slave address.
- slave_dat_o  out  NUM_SLAVES*32  flattened per-slave write data.
- slave_sel_o  out  NUM_SLAVES*4  flattened per-slave byte selects.
- slave_dat_i  in  NUM_SLAVES*32  flattened per-slave read data.
- slave_ack_i  in  NUM_SLAVES  per-slave ack.

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- **IDLE:** while master_stb_i=1, latch adr/dat/sel/we and decode idx = adr[SEL_LSB +: SEL_W].
  - Window match and idx < NUM_SLAVES: go to ACTIVE.
  - Otherwise: go to RESP with err=1 and dat=0. No slave is touched.
- **ACTIVE:** only slave idx sees stb=cyc=1 and the latched we/adr/dat/sel. All other slaves see stb=cyc=we=0.
  - Address, data and sel are broadcast to every slave from the latched registers.
  - On slave_ack_i[idx]: capture slave_dat_i[idx] (also captured on writes) and go to RESP with err=0.
  - Acks from unselected slaves are ignored.
- **Watchdog:** the counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches TIMEOUT with no ack: deassert the slave strobe, go to RESP with err=1, tmo=1, dat=0.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins; no error is raised.
- **RESP:** master_ack_o=1 for exactly one cycle, together with the err/tmo flags. The next state is IDLE.
- Master inputs are not re-sampled until IDLE. If master_stb_i is still high in IDLE, a new transaction starts.
- Writes to an unmapped slot are dropped; the only effect is the error.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, counter 0, latched request 0. Reset is asynchronous and takes effect immediately, including in the middle of a transaction; the interrupted transaction is abandoned with no ack.
- **Mapped access:** stb sampled in IDLE at edge n; slave strobe high in cycle n+1; slave ack at edge m ≥ n+1; master_ack_o high in cycle m+1.
  - Minimum latency is 2 cycles, from the master request being sampled to master_ack_o.
- **Unmapped access:** master_ack_o with master_err_o high in cycle n+1.
- **Timeout:** master_ack_o with master_err_o and master_tmo_o high in cycle n+TIMEOUT+2. Slave strobe high for TIMEOUT+1 cycles.
- master_dat_o holds its value until the next RESP.
- **Master handshake rule:** the master drops stb in the cycle after ack, or keeps it high to issue a back-to-back request. That request is sampled in the following IDLE cycle.

## Structure
- Package wb_switch_pkg holds:
  - the state enum `{IDLE, ACTIVE, RESP}`;
  - slice-width constants: WB_AW=32, WB_DW=32, WB_SW=4.
- Sub-module wb_switch_decode is combinational. It takes adr plus the parameters and returns `{hit, idx}`; it is instantiated once.
- The top module contains the FSM, the latched request, the watchdog and the output fan-out generate loop.

## Test plan
- **Read mapped slot:** NUM_SLAVES=7; read at 0x1000_3004; slave 3 acks 2 cycles after strobe with 0xDEAD_BEEF.
  - master_dat_o=0xDEAD_BEEF, ack at cycle 4, err=0.
  - Only slave_stb_o[3] is ever high.
- **Write mapped slot:** write 0x1234_5678, sel=4'b0011, to 0x1000_0010.
  - Slave 0 sees we=1, adr=0x1000_0010, dat=0x1234_5678, sel=4'b0011.
  - No other slave strobed; ack with err=0.
- **Unmapped accesses:**
  - Address 0x1000_9000 (idx 9 ≥ 7): ack and err at cycle n+1, no slave strobe.
  - Address 0x2000_0000 (window miss): same response.
- **Timeout:** TIMEOUT=4; slave 2 never acks.
  - Strobe high for 5 cycles, then ack, err and tmo together.
  - A second access to slave 2 that acks exactly at count 4 completes with err=0.
- **Reset and ignored acks:** assert rst_i mid-ACTIVE.
  - All outputs return to 0 asynchronously; no ack after release.
  - A following transaction completes normally.
  - A stray slave_ack_i[5] during a slave-1 access is ignored.

Source files
------------

// File: rtl/wb_switch_pkg.sv
// Shared types and bus slice widths for the parametrised Wishbone peripheral switch.
package wb_switch_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/wb_switch_decode.sv
// Combinational address decoder: base-window match plus slave-index range check.
module wb_switch_decode
  import wb_switch_pkg::*;
#(
  parameter int          NUM_SLAVES = 7,
  parameter int          SEL_LSB    = 12,
  parameter int          SEL_W      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic [WB_AW-1:0] i_adr,
  output logic             o_hit,
  output logic [SEL_W-1:0] o_idx
);

  localparam int LP_WIN_LSB = SEL_LSB + SEL_W;
  // With no bits above the index field the window always matches.
  localparam logic [WB_AW-1:0] LP_WIN_MASK =
    (LP_WIN_LSB >= WB_AW) ? {WB_AW{1'b0}} : ({WB_AW{1'b1}} << LP_WIN_LSB);
  localparam logic [SEL_W:0] LP_NUM = (SEL_W + 1)'(NUM_SLAVES);

  logic w_win;

  assign o_idx = i_adr[SEL_LSB +: SEL_W];
  assign w_win = ((i_adr ^ BASE_ADDR) & LP_WIN_MASK) == {WB_AW{1'b0}};
  assign o_hit = w_win && ({1'b0, o_idx} < LP_NUM);

endmodule

// File: rtl/wb_switch_param.sv
// Single-master Wishbone classic switch for up to 16 peripherals, with
// unmapped-slot error response and a per-transaction timeout watchdog.
module wb_switch_param
  import wb_switch_pkg::*;
#(
  parameter int          NUM_SLAVES = 7,
  parameter int          SEL_LSB    = 12,
  parameter int          SEL_W      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          TIMEOUT    = 255,
  parameter int          TIMEOUT_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        master_stb_i,
  input  logic                        master_we_i,
  input  logic [WB_AW-1:0]            master_adr_i,
  input  logic [WB_DW-1:0]            master_dat_i,
  input  logic [WB_SW-1:0]            master_sel_i,
  output logic [WB_DW-1:0]            master_dat_o,
  output logic                        master_ack_o,
  output logic                        master_err_o,
  output logic                        master_tmo_o,
  output logic [NUM_SLAVES-1:0]       slave_stb_o,
  output logic [NUM_SLAVES-1:0]       slave_cyc_o,
  output logic [NUM_SLAVES-1:0]       slave_we_o,
  output logic [NUM_SLAVES*WB_AW-1:0] slave_adr_o,
  output logic [NUM_SLAVES*WB_DW-1:0] slave_dat_o,
  output logic [NUM_SLAVES*WB_SW-1:0] slave_sel_o,
  input  logic [NUM_SLAVES*WB_DW-1:0] slave_dat_i,
  input  logic [NUM_SLAVES-1:0]       slave_ack_i
);

  localparam logic [TIMEOUT_W-1:0]  LP_TMO     = TIMEOUT_W'(TIMEOUT);
  localparam logic [NUM_SLAVES-1:0] LP_ONE     = NUM_SLAVES'(1);
  localparam bit                    LP_WDOG_EN = (TIMEOUT != 0);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [WB_AW-1:0]      r_adr;
  logic [WB_DW-1:0]      r_wdat;
  logic [WB_SW-1:0]      r_sel;
  logic                  r_we;
  logic [SEL_W-1:0]      r_idx;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic [TIMEOUT_W-1:0]  w_cnt_nxt;
  logic [NUM_SLAVES-1:0] r_stb;
  logic [NUM_SLAVES-1:0] w_stb_nxt;
  logic [WB_DW-1:0]      r_dat;
  logic [WB_DW-1:0]      w_dat_nxt;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_tmo;
  logic                  w_ack_nxt;
  logic                  w_err_nxt;
  logic                  w_tmo_nxt;
  logic                  w_latch;
  logic                  w_hit;
  logic [SEL_W-1:0]      w_idx;
  logic                  w_sack;
  logic [WB_DW-1:0]      w_sdat;
  logic                  w_tmo_hit;

  wb_switch_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB),
    .SEL_W      (SEL_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decode (
    .i_adr (master_adr_i),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  // AND-OR select of the addressed slave's ack and read data; others are ignored.
  always_comb begin
    w_sack = 1'b0;
    w_sdat = {WB_DW{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sack = w_sack | (slave_ack_i[i] & (r_idx == SEL_W'(i)));
      w_sdat = w_sdat | (slave_dat_i[i*WB_DW +: WB_DW] & {WB_DW{r_idx == SEL_W'(i)}});
    end
  end

  assign w_tmo_hit = LP_WDOG_EN && (r_cnt == LP_TMO);

  // Next-state and response logic; an ack in the terminal watchdog cycle beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stb_nxt   = r_stb;
    w_dat_nxt   = r_dat;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_tmo_nxt   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (master_stb_i) begin
          w_latch = 1'b1;
          if (w_hit) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = {TIMEOUT_W{1'b0}};
            w_stb_nxt   = LP_ONE << w_idx;
          end else begin
            w_state_nxt = RESP;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            w_dat_nxt   = {WB_DW{1'b0}};
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        if (w_sack) begin
          w_state_nxt = RESP;
          w_stb_nxt   = {NUM_SLAVES{1'b0}};
          w_ack_nxt   = 1'b1;
          w_dat_nxt   = w_sdat;
        end else if (w_tmo_hit) begin
          w_state_nxt = RESP;
          w_stb_nxt   = {NUM_SLAVES{1'b0}};
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_tmo_nxt   = 1'b1;
          w_dat_nxt   = {WB_DW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_stb_nxt   = {NUM_SLAVES{1'b0}};
      end
    endcase
  end

  // State, watchdog, response and latched-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= {TIMEOUT_W{1'b0}};
      r_stb   <= {NUM_SLAVES{1'b0}};
      r_dat   <= {WB_DW{1'b0}};
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
      r_adr   <= {WB_AW{1'b0}};
      r_wdat  <= {WB_DW{1'b0}};
      r_sel   <= {WB_SW{1'b0}};
      r_we    <= 1'b0;
      r_idx   <= {SEL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stb   <= w_stb_nxt;
      r_dat   <= w_dat_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_latch) begin
        r_adr  <= master_adr_i;
        r_wdat <= master_dat_i;
        r_sel  <= master_sel_i;
        r_we   <= master_we_i;
        r_idx  <= w_idx;
      end else begin
        r_adr  <= r_adr;
        r_wdat <= r_wdat;
        r_sel  <= r_sel;
        r_we   <= r_we;
        r_idx  <= r_idx;
      end
    end
  end

  assign master_dat_o = r_dat;
  assign master_ack_o = r_ack;
  assign master_err_o = r_err;
  assign master_tmo_o = r_tmo;
  assign slave_stb_o  = r_stb;
  assign slave_cyc_o  = r_stb;
  assign slave_we_o   = r_stb & {NUM_SLAVES{r_we}};

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_fan
    assign slave_adr_o[g*WB_AW +: WB_AW] = r_adr;
    assign slave_dat_o[g*WB_DW +: WB_DW] = r_wdat;
    assign slave_sel_o[g*WB_SW +: WB_SW] = r_sel;
  end

endmodule

// File: tb/tb_wb_switch_param.sv
// Directed self-checking bench for wb_switch_param (7 slaves, TIMEOUT=4).
module tb_wb_switch_param;

  localparam int NS = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           m_stb = 1'b0;
  logic           m_we = 1'b0;
  logic [31:0]    m_adr = 32'h0;
  logic [31:0]    m_dat = 32'h0;
  logic [3:0]     m_sel = 4'h0;
  logic [31:0]    m_dato;
  logic           m_ack;
  logic           m_err;
  logic           m_tmo;
  logic [NS-1:0]  s_stb;
  logic [NS-1:0]  s_cyc;
  logic [NS-1:0]  s_we;
  logic [NS*32-1:0] s_adr;
  logic [NS*32-1:0] s_dato;
  logic [NS*4-1:0]  s_sel;
  logic [NS*32-1:0] s_dati = '0;
  logic [NS-1:0]  s_ack = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_switch_param #(
    .NUM_SLAVES (NS),
    .SEL_LSB    (12),
    .SEL_W      (4),
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT    (4),
    .TIMEOUT_W  (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .master_stb_i (m_stb),
    .master_we_i  (m_we),
    .master_adr_i (m_adr),
    .master_dat_i (m_dat),
    .master_sel_i (m_sel),
    .master_dat_o (m_dato),
    .master_ack_o (m_ack),
    .master_err_o (m_err),
    .master_tmo_o (m_tmo),
    .slave_stb_o  (s_stb),
    .slave_cyc_o  (s_cyc),
    .slave_we_o   (s_we),
    .slave_adr_o  (s_adr),
    .slave_dat_o  (s_dato),
    .slave_sel_o  (s_sel),
    .slave_dat_i  (s_dati),
    .slave_ack_i  (s_ack)
  );

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one sampling edge; returns in cycle n+1.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    m_we = we; m_adr = adr; m_dat = dat; m_sel = sel; m_stb = 1'b1;
    cyc_step();
    m_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc_step();
    cyc_step();
    n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {m_ack, m_err, m_tmo}); end
    n_vec++; if (m_dato !== 32'h0) begin n_bad++; $display("FAIL rst_dat got %h want 0", m_dato); end
    n_vec++; if ({s_stb, s_cyc, s_we} !== 21'h0) begin n_bad++; $display("FAIL rst_strobes got %h want 0", {s_stb, s_cyc, s_we}); end
    n_vec++; if ({s_adr, s_dato, s_sel} !== '0) begin n_bad++; $display("FAIL rst_fanout got %h want 0", {s_adr, s_sel}); end
    rst = 1'b0;
    cyc_step();
    n_vec++; if (m_ack !== 1'b0) begin n_bad++; $display("FAIL rst_release_ack got %b want 0", m_ack); end
  endtask

  task automatic test_read_mapped();
    for (int i = 0; i < NS; i++) s_dati[i*32 +: 32] = 32'hA5A5_A5A5;
    issue(1'b0, 32'h1000_3004, 32'h0, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      n_vec++; if (s_stb !== 7'b0001000 || s_cyc !== 7'b0001000) begin n_bad++; $display("FAIL rd_stb c%0d got %b/%b want 0001000", k, s_stb, s_cyc); end
      n_vec++; if (s_we !== 7'b0 || m_ack !== 1'b0) begin n_bad++; $display("FAIL rd_we_ack c%0d got %b/%b want 0/0", k, s_we, m_ack); end
      if (k == 3) begin
        s_ack[3] = 1'b1;
        s_dati[3*32 +: 32] = 32'hDEAD_BEEF;
      end
      cyc_step();
    end
    s_ack[3] = 1'b0;
    n_vec++; if (s_adr[3*32 +: 32] !== 32'h1000_3004) begin n_bad++; $display("FAIL rd_adr got %h want 10003004", s_adr[3*32 +: 32]); end
    n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b100) begin n_bad++; $display("FAIL rd_resp c4 got %b want 100", {m_ack, m_err, m_tmo}); end
    n_vec++; if (m_dato !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_dat got %h want deadbeef", m_dato); end
    n_vec++; if (s_stb !== 7'b0) begin n_bad++; $display("FAIL rd_stb_drop got %b want 0", s_stb); end
    cyc_step();
    n_vec++; if (m_ack !== 1'b0 || m_dato !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_hold got %b/%h want 0/deadbeef", m_ack, m_dato); end
  endtask

  task automatic test_write_mapped();
    issue(1'b1, 32'h1000_0010, 32'h1234_5678, 4'b0011);
    n_vec++; if (s_stb !== 7'b0000001 || s_we !== 7'b0000001) begin n_bad++; $display("FAIL wr_stb_we got %b/%b want 0000001", s_stb, s_we); end
    n_vec++; if (s_adr[31:0] !== 32'h1000_0010) begin n_bad++; $display("FAIL wr_adr got %h want 10000010", s_adr[31:0]); end
    n_vec++; if (s_dato[31:0] !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_dat got %h want 12345678", s_dato[31:0]); end
    n_vec++; if (s_sel[3:0] !== 4'b0011) begin n_bad++; $display("FAIL wr_sel got %b want 0011", s_sel[3:0]); end
    s_ack[0] = 1'b1;
    s_dati[31:0] = 32'h0000_00C3;
    cyc_step();
    s_ack[0] = 1'b0;
    n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b100) begin n_bad++; $display("FAIL wr_resp got %b want 100", {m_ack, m_err, m_tmo}); end
    n_vec++; if (m_dato !== 32'h0000_00C3) begin n_bad++; $display("FAIL wr_capture got %h want 000000c3", m_dato); end
    cyc_step();
    n_vec++; if (m_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_pulse got %b want 0", m_ack); end
  endtask

  task automatic test_timeout(input logic ack_at_limit);
    s_dati[2*32 +: 32] = 32'h0BAD_F00D;
    issue(1'b0, 32'h1000_2000, 32'h0, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      n_vec++; if (s_stb !== 7'b0000100 || m_ack !== 1'b0) begin n_bad++; $display("FAIL tmo_stb c%0d got %b/%b want 0000100/0", k, s_stb, m_ack); end
      if (k == 5 && ack_at_limit) s_ack[2] = 1'b1;
      cyc_step();
    end
    s_ack[2] = 1'b0;
    n_vec++; if (s_stb !== 7'b0) begin n_bad++; $display("FAIL tmo_stb_drop got %b want 0", s_stb); end
    if (ack_at_limit) begin
      n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b100) begin n_bad++; $display("FAIL tmo_ack_wins got %b want 100", {m_ack, m_err, m_tmo}); end
      n_vec++; if (m_dato !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL tmo_ack_dat got %h want 0badf00d", m_dato); end
    end else begin
      n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b111) begin n_bad++; $display("FAIL tmo_resp got %b want 111", {m_ack, m_err, m_tmo}); end
      n_vec++; if (m_dato !== 32'h0) begin n_bad++; $display("FAIL tmo_dat got %h want 0", m_dato); end
    end
    cyc_step();
    n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b000) begin n_bad++; $display("FAIL tmo_pulse got %b want 000", {m_ack, m_err, m_tmo}); end
  endtask

  task automatic test_unmapped(input logic [31:0] adr);
    issue(1'b1, adr, 32'hFFFF_FFFF, 4'hF);
    n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b110) begin n_bad++; $display("FAIL unm_resp %h got %b want 110", adr, {m_ack, m_err, m_tmo}); end
    n_vec++; if (m_dato !== 32'h0 || s_stb !== 7'b0) begin n_bad++; $display("FAIL unm_dat_stb %h got %h/%b want 0/0", adr, m_dato, s_stb); end
    cyc_step();
    n_vec++; if (m_ack !== 1'b0 || s_stb !== 7'b0) begin n_bad++; $display("FAIL unm_after %h got %b/%b want 0/0", adr, m_ack, s_stb); end
  endtask

  task automatic test_stray_ack();
    issue(1'b0, 32'h1000_1000, 32'h0, 4'hF);
    s_ack[5] = 1'b1;
    s_dati[5*32 +: 32] = 32'h5555_5555;
    for (int k = 2; k <= 3; k++) begin
      cyc_step();
      n_vec++; if (m_ack !== 1'b0 || s_stb !== 7'b0000010) begin n_bad++; $display("FAIL stray c%0d got %b/%b want 0/0000010", k, m_ack, s_stb); end
    end
    s_ack[5] = 1'b0;
    s_ack[1] = 1'b1;
    s_dati[1*32 +: 32] = 32'h1111_2222;
    cyc_step();
    s_ack[1] = 1'b0;
    n_vec++; if ({m_ack, m_err} !== 2'b10 || m_dato !== 32'h1111_2222) begin n_bad++; $display("FAIL stray_resp got %b/%h want 10/11112222", {m_ack, m_err}, m_dato); end
    cyc_step();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h1000_4000, 32'h0, 4'hF);
    n_vec++; if (s_stb !== 7'b0010000) begin n_bad++; $display("FAIL rmid_stb got %b want 0010000", s_stb); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({s_stb, s_cyc, m_ack} !== 15'h0) begin n_bad++; $display("FAIL rmid_async got %h want 0", {s_stb, s_cyc, m_ack}); end
    n_vec++; if (m_dato !== 32'h0 || s_adr !== '0) begin n_bad++; $display("FAIL rmid_regs got %h/%h want 0", m_dato, s_adr[4*32 +: 32]); end
    cyc_step();
    rst = 1'b0;
    s_ack[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc_step();
      n_vec++; if (m_ack !== 1'b0 || s_stb !== 7'b0) begin n_bad++; $display("FAIL rmid_noack c%0d got %b/%b want 0/0", k, m_ack, s_stb); end
    end
    s_ack[4] = 1'b0;
  endtask

  task automatic test_after_reset();
    issue(1'b0, 32'h1000_6000, 32'h0, 4'hF);
    n_vec++; if (s_stb !== 7'b1000000) begin n_bad++; $display("FAIL post_stb got %b want 1000000", s_stb); end
    s_ack[6] = 1'b1;
    s_dati[6*32 +: 32] = 32'h6666_0006;
    cyc_step();
    s_ack[6] = 1'b0;
    n_vec++; if ({m_ack, m_err, m_tmo} !== 3'b100 || m_dato !== 32'h6666_0006) begin n_bad++; $display("FAIL post_resp got %b/%h want 100/66660006", {m_ack, m_err, m_tmo}, m_dato); end
    cyc_step();
  endtask

  initial begin
    test_reset();
    test_read_mapped();
    test_write_mapped();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_unmapped(32'h1000_9000);
    test_unmapped(32'h2000_0000);
    test_stray_ack();
    test_reset_mid();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit got expired want completion");
    $fatal(1);
  end

endmodule
